// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the mem_stage_lsu pipeline memory stage.
package mem_stage_pkg;

    typedef enum logic [3:0] {
        MEM_X = 4'd0,
        LB    = 4'd1,
        LBU   = 4'd2,
        LH    = 4'd3,
        LHU   = 4'd4,
        LW    = 4'd5,
        LWU   = 4'd6,
        LD    = 4'd7,
        SB    = 4'd8,
        SH    = 4'd9,
        SW    = 4'd10,
        SD    = 4'd11
    } mem_op_t;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_REQ   = 2'd1;
    localparam state_t ST_RESP  = 2'd2;
    localparam state_t ST_DRAIN = 2'd3;

    localparam logic [63:0] REGPC_NOP_DEFAULT = 64'h0000_0000_0000_0000;

    function automatic logic is_load(mem_op_t op);
        return (op >= LB) && (op <= LD);
    endfunction

    function automatic logic is_store(mem_op_t op);
        return (op >= SB) && (op <= SD);
    endfunction

    // Access size as log2 of the byte count (0=byte .. 3=dword).
    function automatic logic [1:0] access_size(mem_op_t op);
        case (op)
            LH, LHU, SH:  return 2'd1;
            LW, LWU, SW:  return 2'd2;
            LD, SD:       return 2'd3;
            default:      return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Memory command/response bus between mem_stage_lsu (master) and the memory (slave).
interface mem_stage_lsu_if #(
    parameter int XLEN = 32
);
    logic            mem_cmd_start;
    logic            mem_cmd_write;
    logic            mem_cmd_ready;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_wmask;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_rdata_valid;

    modport master (
        output mem_cmd_start, mem_cmd_write, mem_addr, mem_wdata, mem_wmask,
        input  mem_cmd_ready, mem_rdata, mem_rdata_valid
    );

    modport slave (
        input  mem_cmd_start, mem_cmd_write, mem_addr, mem_wdata, mem_wmask,
        output mem_cmd_ready, mem_rdata, mem_rdata_valid
    );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane alignment: store replicate/mask and load extract/extend.
// MEM_STAGE_MISALIGN_TRAP_EN adds a misalign flag output.
module mem_lane_align
    import mem_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  mem_op_t                   op,
    input  logic [$clog2(XLEN/8)-1:0] off,
    input  logic [XLEN-1:0]           wdata,
    input  logic [XLEN-1:0]           rdata,
    output logic [XLEN-1:0]           wdata_lane,
    output logic [XLEN-1:0]           wmask_lane,
    output logic [XLEN-1:0]           rdata_ext
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    ,
    output logic                      misalign
`endif
);
    localparam int OFF_W = $clog2(XLEN/8);
    localparam int IDX_W = $clog2(XLEN);

    logic [1:0]      size;
    int              lane_bits;
    int              low;
    int              shamt;
    logic [XLEN-1:0] shifted;
    logic            sign;

    // Offset bits below the access size are dropped so the lane is always naturally aligned.
    always_comb begin
        size = access_size(op);
        if (int'(size) > OFF_W) size = 2'(OFF_W);
        lane_bits  = 8 << size;
        low        = int'(off) & ((1 << size) - 1);
        shamt      = 8 * (int'(off) - low);
        shifted    = rdata >> shamt;
        sign       = (op == LB) || (op == LH) || (op == LW);
        wdata_lane = '0;
        wmask_lane = '0;
        rdata_ext  = '0;
        for (int i = 0; i < XLEN; i++) begin
            wdata_lane[i] = wdata[IDX_W'(i % lane_bits)];
            wmask_lane[i] = (i >= shamt) && (i < shamt + lane_bits);
            rdata_ext[i]  = (i < lane_bits) ? shifted[i]
                                            : (sign & shifted[IDX_W'(lane_bits - 1)]);
        end
    end

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    assign misalign = (low != 0);
`endif

endmodule

// File: rtl/mem_stage_lsu.sv
// Pipeline memory stage: valid/ready in and out, load/store issue with lane alignment and flush draining.
// Define MEM_STAGE_MISALIGN_TRAP_EN to turn misaligned accesses into flagged non-memory results.
module mem_stage_lsu
    import mem_stage_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              PASS_W    = 48,
    parameter logic [XLEN-1:0] REGPC_NOP = REGPC_NOP_DEFAULT[XLEN-1:0]
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_addr,
    input  logic [XLEN-1:0]   in_wdata,
    input  logic [3:0]        in_mem_op,
    input  logic [PASS_W-1:0] in_pass,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_alu,
    output logic [XLEN-1:0]   out_rdata,
    output logic [PASS_W-1:0] out_pass,
    output logic              out_misalign,
    mem_stage_lsu_if.master   mem
);
    localparam int OFF_W = $clog2(XLEN/8);

    state_t            state;
    mem_op_t           in_op;
    mem_op_t           req_op;
    mem_op_t           align_op;
    logic [OFF_W-1:0]  align_off;
    logic [XLEN-1:0]   req_pc;
    logic [XLEN-1:0]   req_alu;
    logic [XLEN-1:0]   req_wdata;
    logic [XLEN-1:0]   req_wmask;
    logic [PASS_W-1:0] req_pass;
    logic              req_write;
    logic [XLEN-1:0]   lane_wdata;
    logic [XLEN-1:0]   lane_wmask;
    logic [XLEN-1:0]   lane_rdata;
    logic              trap_hit;
    logic              accept;
    logic              in_is_mem;

    assign in_op     = mem_op_t'(in_mem_op);
    assign in_ready  = (state == ST_IDLE) && (!out_valid || out_ready) && !flush;
    assign accept    = in_valid && in_ready;
    assign in_is_mem = (is_load(in_op) || is_store(in_op)) && !trap_hit;

    // The aligner sees the incoming op while idle and the held request otherwise.
    assign align_op  = (state == ST_IDLE) ? in_op : req_op;
    assign align_off = (state == ST_IDLE) ? in_addr[OFF_W-1:0] : req_alu[OFF_W-1:0];

    mem_lane_align #(
        .XLEN (XLEN)
    ) u_align (
        .op         (align_op),
        .off        (align_off),
        .wdata      (in_wdata),
        .rdata      (mem.mem_rdata),
        .wdata_lane (lane_wdata),
        .wmask_lane (lane_wmask),
        .rdata_ext  (lane_rdata)
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        ,
        .misalign   (trap_hit)
`endif
    );

`ifndef MEM_STAGE_MISALIGN_TRAP_EN
    assign trap_hit = 1'b0;
`endif

    assign mem.mem_cmd_start = (state == ST_REQ) && !flush;
    assign mem.mem_cmd_write = (state == ST_REQ) && !flush && req_write;
    assign mem.mem_addr      = {req_alu[XLEN-1:OFF_W], {OFF_W{1'b0}}};
    assign mem.mem_wdata     = req_wdata;
    assign mem.mem_wmask     = req_wmask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            out_valid    <= 1'b0;
            out_pc       <= REGPC_NOP;
            out_alu      <= '0;
            out_rdata    <= '0;
            out_pass     <= '0;
            out_misalign <= 1'b0;
            req_op       <= MEM_X;
            req_pc       <= '0;
            req_alu      <= '0;
            req_wdata    <= '0;
            req_wmask    <= '0;
            req_pass     <= '0;
            req_write    <= 1'b0;
        end else if (flush) begin
            out_valid    <= 1'b0;
            out_pc       <= REGPC_NOP;
            out_alu      <= '0;
            out_rdata    <= '0;
            out_pass     <= '0;
            out_misalign <= 1'b0;
            // A killed load still owes a response unless it arrives this very cycle.
            case (state)
                ST_RESP:  state <= mem.mem_rdata_valid ? ST_IDLE : ST_DRAIN;
                ST_DRAIN: state <= mem.mem_rdata_valid ? ST_IDLE : ST_DRAIN;
                default:  state <= ST_IDLE;
            endcase
        end else begin
            if (out_valid && out_ready) begin
                out_valid    <= 1'b0;
                out_pc       <= REGPC_NOP;
                out_alu      <= '0;
                out_rdata    <= '0;
                out_pass     <= '0;
                out_misalign <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (accept && in_is_mem) begin
                        req_op    <= in_op;
                        req_pc    <= in_pc;
                        req_alu   <= in_addr;
                        req_wdata <= lane_wdata;
                        req_wmask <= lane_wmask;
                        req_pass  <= in_pass;
                        req_write <= is_store(in_op);
                        state     <= ST_REQ;
                    end else if (accept) begin
                        out_valid    <= 1'b1;
                        out_pc       <= in_pc;
                        out_alu      <= in_addr;
                        out_rdata    <= '0;
                        out_pass     <= in_pass;
                        out_misalign <= trap_hit;
                    end
                end
                ST_REQ: begin
                    if (mem.mem_cmd_ready && req_write) begin
                        out_valid    <= 1'b1;
                        out_pc       <= req_pc;
                        out_alu      <= req_alu;
                        out_rdata    <= '0;
                        out_pass     <= req_pass;
                        out_misalign <= 1'b0;
                        state        <= ST_IDLE;
                    end else if (mem.mem_cmd_ready) begin
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (mem.mem_rdata_valid) begin
                        out_valid    <= 1'b1;
                        out_pc       <= req_pc;
                        out_alu      <= req_alu;
                        out_rdata    <= lane_rdata;
                        out_pass     <= req_pass;
                        out_misalign <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
                default: begin
                    if (mem.mem_rdata_valid) state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed scoreboard bench for mem_stage_lsu at XLEN=32.
module tb_mem_stage_lsu;
    import mem_stage_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [47:0] pass;
        logic        mis;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [3:0]  in_mem_op;
    logic [47:0] in_pass;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_alu;
    logic [31:0] out_rdata;
    logic [47:0] out_pass;
    logic        out_misalign;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    mem_stage_lsu_if #(.XLEN(32)) mif ();

    mem_stage_lsu #(
        .XLEN   (32),
        .PASS_W (48)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_addr      (in_addr),
        .in_wdata     (in_wdata),
        .in_mem_op    (in_mem_op),
        .in_pass      (in_pass),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_alu      (out_alu),
        .out_rdata    (out_rdata),
        .out_pass     (out_pass),
        .out_misalign (out_misalign),
        .mem          (mif)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] rdata,
                        input logic [47:0] pass, input logic mis);
        exp_t e;
        e.pc = pc; e.alu = alu; e.rdata = rdata; e.pass = pass; e.mis = mis;
        sb.push_back(e);
    endtask

    task automatic offer(input logic [3:0] op, input logic [31:0] pc, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [47:0] pass);
        bit got = 1'b0;
        in_mem_op = op; in_pc = pc; in_addr = addr; in_wdata = wdata; in_pass = pass;
        in_valid  = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = in_ready;
        end
        check("accept_timeout", {63'd0, got}, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic respond(input int gap, input logic [31:0] data);
        repeat (gap) begin
            @(negedge clk);
            check("resp_wait_out_valid", {63'd0, out_valid}, 64'd0);
            @(posedge clk); #1;
        end
        mif.mem_rdata = data; mif.mem_rdata_valid = 1'b1;
        @(posedge clk); #1;
        mif.mem_rdata_valid = 1'b0;
        @(negedge clk);
        check("load_out_valid", {63'd0, out_valid}, 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic do_load(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                           input logic [31:0] exp_rdata);
        push(32'h200, addr, exp_rdata, 48'h0000_0000_0BAD, 1'b0);
        mif.mem_cmd_ready = 1'b1;
        offer(op, 32'h200, addr, 32'h0, 48'h0000_0000_0BAD);
        @(negedge clk);
        check("load_cmd_start", {63'd0, mif.mem_cmd_start}, 64'd1);
        check("load_cmd_write", {63'd0, mif.mem_cmd_write}, 64'd0);
        check("load_mem_addr", {32'd0, mif.mem_addr}, {32'd0, addr & 32'hFFFF_FFFC});
        @(posedge clk); #1;
        mif.mem_cmd_ready = 1'b0;
        respond(2, data);
    endtask

    // Scoreboard: every consumed result must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            check("sb_nonempty", {63'd0, sb.size() != 0}, 64'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("out_pc", {32'd0, out_pc}, {32'd0, e.pc});
                check("out_alu", {32'd0, out_alu}, {32'd0, e.alu});
                check("out_rdata", {32'd0, out_rdata}, {32'd0, e.rdata});
                check("out_pass", {16'd0, out_pass}, {16'd0, e.pass});
                check("out_misalign", {63'd0, out_misalign}, {63'd0, e.mis});
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_addr = '0; in_wdata = '0;
        in_mem_op = MEM_X; in_pass = '0; out_ready = 1'b1;
        mif.mem_cmd_ready = 1'b0; mif.mem_rdata = '0; mif.mem_rdata_valid = 1'b0;

        #12;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_cmd_start", {63'd0, mif.mem_cmd_start}, 64'd0);
        check("rst_cmd_write", {63'd0, mif.mem_cmd_write}, 64'd0);
        check("rst_out_pc", {32'd0, out_pc}, 64'd0);
        check("rst_out_alu", {32'd0, out_alu}, 64'd0);
        check("rst_out_rdata", {32'd0, out_rdata}, 64'd0);
        check("rst_out_pass", {16'd0, out_pass}, 64'd0);
        check("rst_out_misalign", {63'd0, out_misalign}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_in_ready", {63'd0, in_ready}, 64'd1);

        // SB to the top byte lane with the command accepted immediately.
        mif.mem_cmd_ready = 1'b1;
        push(32'h100, 32'h1003, 32'h0, 48'h1234_5678_9ABC, 1'b0);
        offer(SB, 32'h100, 32'h1003, 32'h0000_00AB, 48'h1234_5678_9ABC);
        @(negedge clk);
        check("sb_cmd_start", {63'd0, mif.mem_cmd_start}, 64'd1);
        check("sb_cmd_write", {63'd0, mif.mem_cmd_write}, 64'd1);
        check("sb_mem_addr", {32'd0, mif.mem_addr}, 64'h1000);
        check("sb_wmask", {32'd0, mif.mem_wmask}, 64'hFF00_0000);
        check("sb_wdata_lane3", {56'd0, mif.mem_wdata[31:24]}, 64'hAB);
        check("sb_out_valid_early", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        check("sb_out_valid_2cyc", {63'd0, out_valid}, 64'd1);
        @(posedge clk); #1;

        // SH to the upper halfword.
        push(32'h104, 32'h1006, 32'h0, 48'h0, 1'b0);
        offer(SH, 32'h104, 32'h1006, 32'h1234_BEEF, 48'h0);
        @(negedge clk);
        check("sh_wmask", {32'd0, mif.mem_wmask}, 64'hFFFF_0000);
        check("sh_wdata_hi", {48'd0, mif.mem_wdata[31:16]}, 64'hBEEF);
        @(negedge clk);
        @(posedge clk); #1;

        do_load(LB,  32'h2001, 32'h0000_8000, 32'hFFFF_FF80);
        do_load(LBU, 32'h2001, 32'h0000_8000, 32'h0000_0080);
        do_load(LH,  32'h2002, 32'h8765_0000, 32'hFFFF_8765);
        do_load(LHU, 32'h2002, 32'h8765_0000, 32'h0000_8765);

        // LW with the memory stalling the command for four cycles.
        mif.mem_cmd_ready = 1'b0;
        push(32'h300, 32'h4008, 32'h1234_5678, 48'h55, 1'b0);
        offer(LW, 32'h300, 32'h4008, 32'h0, 48'h55);
        in_valid = 1'b1; in_mem_op = MEM_X;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_cmd_start", {63'd0, mif.mem_cmd_start}, 64'd1);
            check("stall_mem_addr", {32'd0, mif.mem_addr}, 64'h4008);
            check("stall_in_ready", {63'd0, in_ready}, 64'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        mif.mem_cmd_ready = 1'b1;
        @(posedge clk); #1;
        mif.mem_cmd_ready = 1'b0;
        respond(0, 32'h1234_5678);

        // Flush while waiting for read data; the late response must be drained.
        mif.mem_cmd_ready = 1'b1;
        offer(LH, 32'h500, 32'h5002, 32'h0, 48'h0);
        @(posedge clk); #1;
        mif.mem_cmd_ready = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        check("flush_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        push(32'h600, 32'h66, 32'h0, 48'hFEED, 1'b0);
        in_mem_op = MEM_X; in_pc = 32'h600; in_addr = 32'h66; in_pass = 48'hFEED; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("drain_in_ready", {63'd0, in_ready}, 64'd0);
            check("drain_out_valid", {63'd0, out_valid}, 64'd0);
            @(posedge clk); #1;
        end
        mif.mem_rdata = 32'hFFFF_FFFF; mif.mem_rdata_valid = 1'b1;
        @(posedge clk); #1;
        mif.mem_rdata_valid = 1'b0;
        offer(MEM_X, 32'h600, 32'h66, 32'h0, 48'hFEED);
        @(negedge clk);
        check("post_drain_out_valid", {63'd0, out_valid}, 64'd1);
        @(posedge clk); #1;

        // Output backpressure holds the result and blocks the next instruction.
        out_ready = 1'b0;
        push(32'h700, 32'h11, 32'h0, 48'hAAA, 1'b0);
        offer(MEM_X, 32'h700, 32'h11, 32'h0, 48'hAAA);
        push(32'h704, 32'h22, 32'h0, 48'hBBB, 1'b0);
        in_mem_op = MEM_X; in_pc = 32'h704; in_addr = 32'h22; in_pass = 48'hBBB; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", {63'd0, in_ready}, 64'd0);
            check("bp_out_valid", {63'd0, out_valid}, 64'd1);
            check("bp_out_pc", {32'd0, out_pc}, 64'h700);
            check("bp_out_pass", {16'd0, out_pass}, 64'hAAA);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_next_out_pc", {32'd0, out_pc}, 64'h704);
        @(posedge clk); #1;

        // Reset in the middle of a stalled command.
        mif.mem_cmd_ready = 1'b0;
        offer(LW, 32'h800, 32'h4100, 32'h0, 48'h0);
        @(negedge clk);
        check("midrst_cmd_before", {63'd0, mif.mem_cmd_start}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_cmd_after", {63'd0, mif.mem_cmd_start}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;

        // Misaligned LW: trapped as a flagged result, or aligned down to a plain load.
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        mif.mem_cmd_ready = 1'b1;
        push(32'h900, 32'h3002, 32'h0, 48'h0, 1'b1);
        offer(LW, 32'h900, 32'h3002, 32'h0, 48'h0);
        @(negedge clk);
        check("trap_no_cmd", {63'd0, mif.mem_cmd_start}, 64'd0);
        check("trap_out_valid", {63'd0, out_valid}, 64'd1);
        check("trap_out_misalign", {63'd0, out_misalign}, 64'd1);
        @(posedge clk); #1;
        mif.mem_cmd_ready = 1'b0;
`else
        do_load(LW, 32'h3002, 32'hCAFE_BABE, 32'hCAFE_BABE);
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("sb_drained", {32'd0, 32'(sb.size())}, 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Parametrised successor to the pipeline memory stage, sitting between execute and writeback.
- Accepts one instruction at a time over a valid/ready handshake and passes non-memory instructions through with one-cycle latency.
- Issues loads and stores on the shared memory command interface.
- Adds byte-lane alignment of store data and mask, offset-correct load extraction, flush with response draining, output backpressure, and a generic sideband passthrough.

Parameters:
- XLEN, 32, data/address width; legal values 32 or 64.
- PASS_W, 48, width of the opaque sideband bundle carried alongside each instruction (wb_sel, wb_addr, rf_wen, br/jmp/ecall flags).
- REGPC_NOP, 32'h0000_0000 zero-extended to XLEN, PC value driven on empty output.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  kill the in-flight instruction (writeback branch hazard).
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_pc  in  XLEN  instruction PC.
- in_addr  in  XLEN  effective address (ALU result).
- in_wdata  in  XLEN  store data (rs2).
- in_mem_op  in  4  memory op code from the package.
- in_pass  in  PASS_W  sideband bundle.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream consumes the result.
- out_pc  out  XLEN  PC of the result.
- out_alu  out  XLEN  in_addr passthrough.
- out_rdata  out  XLEN  extended load data; 0 for non-loads.
- out_pass  out  PASS_W  sideband.
- out_misalign  out  1  misaligned-access flag (feature only; tied 0 otherwise).
- mem_cmd_start  out  1  command request.
- mem_cmd_write  out  1  request is a store.
- mem_cmd_ready  in  1  memory accepts the command this cycle.
- mem_addr  out  XLEN  word-aligned address.
- mem_wdata  out  XLEN  lane-shifted store data.
- mem_wmask  out  XLEN  lane-shifted bit mask.
- mem_rdata  in  XLEN  read data.
- mem_rdata_valid  in  1  read data valid, one cycle per load.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, out_valid=0, mem_cmd_start=0, mem_cmd_write=0.
  - out_pc=REGPC_NOP; out_alu, out_rdata, out_pass and out_misalign all 0.
- States:
  - IDLE: accept and dispatch.
  - REQ: command held until accepted.
  - RESP: wait for read data.
  - DRAIN: discard the response of a flushed load.
- Handshake and dispatch:
  - in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush. Accept = in_valid && in_ready.
  - Non-memory accept (MEM_X): the output register loads the next edge, so out_valid rises one cycle after accept.
  - Memory accept: the request is registered into REQ the next cycle, and mem_cmd_start is driven from the registers. The command fields (addr, wdata, wmask, write) stay stable until mem_cmd_ready.
  - Store accepted by the command (REQ with mem_cmd_ready): load the output register and go to IDLE.
  - Load accepted by the command: go to RESP. When mem_rdata_valid arrives, load the output register with the extended data and go to IDLE. The output register is guaranteed empty at that point, because accept required it to be free.
  - out_valid holds until out_ready; output fields are stable while out_valid && !out_ready.
- Alignment:
  - off = addr[log2(XLEN/8)-1:0]; mem_addr = addr with off cleared.
  - Byte ops (SB): wdata[7:0] replicated, mask 0xFF shifted left by 8*off.
  - Halfword ops (SH): 16-bit lane at 8*off.
  - Word ops: SW, and LW/SW under XLEN=32, use the full lane; under XLEN=64, SW uses the 32-bit lane at 8*off.
  - Loads shift mem_rdata right by 8*off, then extend:
    - Sign-extend: LB, LH, LW(64).
    - Zero-extend: LBU, LHU, LWU.
    - No extension: LW(32), LD.
- Flush (highest priority, all states):
  - Clears out_valid and any uncommitted accept.
  - In REQ: drop mem_cmd_start the same cycle and go to IDLE. If mem_cmd_ready coincides with flush, the command is not issued.
  - In RESP: go to DRAIN. DRAIN returns to IDLE on mem_rdata_valid without writing the output. A flush and a valid response in the same cycle go directly to IDLE.
  - A committed store is not undone.
- Reset mid-transaction returns to IDLE immediately; no response tracking survives reset.

Optional Feature:
- MEM_STAGE_MISALIGN_TRAP_EN defined:
  - A halfword/word/dword access whose off is not a multiple of its size issues no memory command.
  - The result is produced like a non-memory op with out_misalign=1 and out_rdata=0.
- Not defined: low address bits beyond the access size are ignored (the address is forced aligned to the access size) and out_misalign is tied 0.

Decomposition:
- Shared package mem_stage_pkg:
  - mem_op_t encoding: MEM_X=0, LB, LBU, LH, LHU, LW, LWU, LD, SB, SH, SW, SD.
  - state_t.
  - Helpers is_load/is_store/access_size.
  - REGPC_NOP default.
- One natural sub-module: mem_lane_align. It is purely combinational and owns store shift/mask generation and load extract/extend, shared by both paths.

Test Plan:
- XLEN=32, SB addr 0x1003 data 0xAB, mem_cmd_ready held 1 -> mem_addr 0x1000, wmask 0xFF000000, wdata lane3=0xAB; out_valid 2 cycles after accept.
- LB addr 0x2001, mem_rdata 0x0000_8000 returned 3 cycles after the command -> out_rdata 0xFFFF_FF80. Same with LBU -> 0x0000_0080.
- mem_cmd_ready low for 4 cycles during LW -> mem_cmd_start/addr stable for all 4 cycles; in_ready=0 throughout.
- Flush in RESP, then a new op offered -> no out_valid; in_ready=0 until mem_rdata_valid is drained; the subsequent op completes normally.
- out_ready=0 with a pending result, then a new MEM_X offered -> in_ready=0, outputs frozen; out_ready=1 -> the next result appears the following cycle.
- With MEM_STAGE_MISALIGN_TRAP_EN, LW addr 0x3002 -> no mem_cmd_start, out_misalign=1. Without the macro -> mem_addr 0x3000 and a normal load.
